hash_generator: RTL and testbench

Keystream source for the stream cipher. It sits directly upstream of the encryption block. It holds a 32-bit xorshift state, optionally re-keyed from a 4-byte seed. On each single-cycle request it runs `ROUNDS` mixing steps and returns one keystream byte with a one-cycle valid pulse. The published `hash_generator_state` tells the encryption block when a request will be accepted.

---
 rtl/hash_generator.sv | 151 +++++++++++++++
 tb/tb_hash_generator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_generator.sv
// Keystream byte source for the stream cipher: a 32-bit xorshift state, optionally
// re-keyed from a 4-byte seed. Define HASH_GEN_COUNTER_EN to add the bytes_generated counter.
package types_pkg;
    typedef enum logic [1:0] {
        H_GROUND  = 2'd0,
        H_SEEDING = 2'd1,
        H_READY   = 2'd2,
        H_BUSY    = 2'd3
    } hash_generator_state_t;
endpackage

module hash_generator #(
    parameter int unsigned ROUNDS       = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'hA5A5_5A5A
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [7:0]                         seed_byte,
    input  logic                               seed_byte_pulse,
    input  logic                               request_byte_pulse,
    output logic [7:0]                         hash_byte,
    output logic                               hash_byte_pulse,
    output types_pkg::hash_generator_state_t   hash_generator_state
`ifdef HASH_GEN_COUNTER_EN
    ,
    output logic [15:0]                        bytes_generated
`endif
);
    import types_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    function automatic logic [31:0] xorshift(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    hash_generator_state_t state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] seed_sr_q, seed_sr_d;
    logic [2:0]  seed_cnt_q, seed_cnt_d;
    logic [3:0]  round_cnt_q, round_cnt_d;
    logic        seeded_q, seeded_d;
    logic [7:0]  hash_byte_q, hash_byte_d;
    logic        pulse_q, pulse_d;

    logic [31:0] x_step;
    logic [31:0] seed_word;

    assign x_step    = xorshift(x_q);
    assign seed_word = {seed_sr_q[23:0], seed_byte};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= H_GROUND;
            x_q         <= DEFAULT_SEED;
            seed_sr_q   <= 32'd0;
            seed_cnt_q  <= 3'd0;
            round_cnt_q <= 4'd0;
            seeded_q    <= 1'b0;
            hash_byte_q <= 8'd0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            seed_sr_q   <= seed_sr_d;
            seed_cnt_q  <= seed_cnt_d;
            round_cnt_q <= round_cnt_d;
            seeded_q    <= seeded_d;
            hash_byte_q <= hash_byte_d;
            pulse_q     <= pulse_d;
        end
    end

    // A seed strobe outranks a simultaneous request; requests are dropped while seeding or busy.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        seed_sr_d   = seed_sr_q;
        seed_cnt_d  = seed_cnt_q;
        round_cnt_d = round_cnt_q;
        seeded_d    = seeded_q;
        hash_byte_d = hash_byte_q;
        pulse_d     = 1'b0;
        case (state_q)
            H_GROUND, H_READY: begin
                if (seed_byte_pulse) begin
                    seed_sr_d  = seed_word;
                    seed_cnt_d = 3'd1;
                    state_d    = H_SEEDING;
                end else if (request_byte_pulse) begin
                    round_cnt_d = 4'd0;
                    state_d     = H_BUSY;
                end
            end
            H_SEEDING: begin
                if (seed_byte_pulse) begin
                    seed_sr_d = seed_word;
                    if (seed_cnt_q == 3'd3) begin
                        x_d        = (seed_word == 32'd0) ? DEFAULT_SEED : seed_word;
                        seeded_d   = 1'b1;
                        seed_cnt_d = 3'd0;
                        state_d    = H_READY;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
            end
            H_BUSY: begin
                x_d         = x_step;
                round_cnt_d = round_cnt_q + 4'd1;
                if (round_cnt_q == LAST_ROUND) begin
                    hash_byte_d = x_step[31:24] ^ x_step[7:0];
                    pulse_d     = 1'b1;
                    state_d     = seeded_q ? H_READY : H_GROUND;
                end
            end
            default: begin
                state_d = H_GROUND;
            end
        endcase
    end

    assign hash_byte            = hash_byte_q;
    assign hash_byte_pulse      = pulse_q;
    assign hash_generator_state = state_q;

`ifdef HASH_GEN_COUNTER_EN
    logic [15:0] count_q;
    logic        seed_done;

    assign seed_done = (state_q == H_SEEDING) && seed_byte_pulse && (seed_cnt_q == 3'd3);

    // Counts delivered bytes since the last completed seed, saturating.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= 16'd0;
        end else if (seed_done) begin
            count_q <= 16'd0;
        end else if (pulse_d && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bytes_generated = count_q;
`endif

endmodule

// File: tb/tb_hash_generator.sv
// Scoreboard bench for hash_generator: randomized and directed stimulus against a
// transaction-level keystream model; a separate monitor checks every output pulse.
module tb_hash_generator;
    import types_pkg::*;

    localparam int          ROUNDS = 4;
    localparam logic [31:0] DEF    = 32'hA5A5_5A5A;

    logic                  clk = 1'b0;
    logic                  nrst = 1'b0;
    logic [7:0]            seed_byte = 8'd0;
    logic                  seed_byte_pulse = 1'b0;
    logic                  request_byte_pulse = 1'b0;
    logic [7:0]            hash_byte;
    logic                  hash_byte_pulse;
    hash_generator_state_t dutState;
`ifdef HASH_GEN_COUNTER_EN
    logic [15:0]           bytes_generated;
`endif

    hash_generator #(.ROUNDS(ROUNDS), .DEFAULT_SEED(DEF)) dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .seed_byte            (seed_byte),
        .seed_byte_pulse      (seed_byte_pulse),
        .request_byte_pulse   (request_byte_pulse),
        .hash_byte            (hash_byte),
        .hash_byte_pulse      (hash_byte_pulse),
        .hash_generator_state (dutState)
`ifdef HASH_GEN_COUNTER_EN
        ,
        .bytes_generated      (bytes_generated)
`endif
    );

    always #5 clk = ~clk;

    int unsigned edgeCount = 0;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned edgeNum;
    } exp_t;
    exp_t expQ[$];

    int total = 0;
    int bad   = 0;

    // Reference model state, updated once per upcoming clock edge.
    hash_generator_state_t mState;
    logic [31:0] mX, mSeedWord;
    int          mSeedCnt, mBusyLeft, mCount;
    bit          mSeeded, mValid = 1'b0;
    logic [7:0]  mHashByte, mPending;
    logic [7:0]  refSeq[3];

    function automatic logic [31:0] refStep(input logic [31:0] v);
        logic [31:0] r;
        r = v ^ (v << 13);
        r = r ^ (r >> 17);
        r = r ^ (r << 5);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    task automatic modelEdge(input bit rstN, input bit seedP, input logic [7:0] seedB, input bit reqP);
        exp_t e;
        if (!rstN) begin
            mValid    = 1'b1;
            mState    = H_GROUND;
            mX        = DEF;
            mSeedCnt  = 0;
            mBusyLeft = 0;
            mSeeded   = 1'b0;
            mHashByte = 8'd0;
            mCount    = 0;
        end else if (mValid) begin
            case (mState)
                H_GROUND, H_READY: begin
                    if (seedP) begin
                        mSeedWord = {mSeedWord[23:0], seedB};
                        mSeedCnt  = 1;
                        mState    = H_SEEDING;
                    end else if (reqP) begin
                        for (int i = 0; i < ROUNDS; i++) mX = refStep(mX);
                        mPending  = mX[31:24] ^ mX[7:0];
                        mBusyLeft = ROUNDS;
                        mState    = H_BUSY;
                    end
                end
                H_SEEDING: begin
                    if (seedP) begin
                        mSeedWord = {mSeedWord[23:0], seedB};
                        mSeedCnt++;
                        if (mSeedCnt == 4) begin
                            mX       = (mSeedWord == 32'd0) ? DEF : mSeedWord;
                            mSeeded  = 1'b1;
                            mSeedCnt = 0;
                            mCount   = 0;
                            mState   = H_READY;
                        end
                    end
                end
                default: begin
                    mBusyLeft--;
                    if (mBusyLeft == 0) begin
                        e.data    = mPending;
                        e.edgeNum = edgeCount + 1;
                        expQ.push_back(e);
                        mHashByte = mPending;
                        if (mCount < 65535) mCount++;
                        mState = mSeeded ? H_READY : H_GROUND;
                    end
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit seedP, input logic [7:0] seedB, input bit reqP);
        @(negedge clk);
        if (mValid) begin
            checkOutput("state", 32'(dutState), 32'(mState));
            checkOutput("hash_byte_hold", 32'(hash_byte), 32'(mHashByte));
`ifdef HASH_GEN_COUNTER_EN
            checkOutput("bytes_generated", 32'(bytes_generated), 32'(mCount));
`endif
        end
        nrst               = rstN;
        seed_byte_pulse    = seedP;
        seed_byte          = seedB;
        request_byte_pulse = reqP;
        modelEdge(rstN, seedP, seedB, reqP);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic seedIn(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic request();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    endtask

    // Monitor: every pulse must match the oldest expected byte and its edge.
    always @(negedge clk) begin
        exp_t e;
        if (mValid && hash_byte_pulse === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse: got byte %h expected no pulse (edge %0d)", hash_byte, edgeCount);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse_byte", 32'(hash_byte), 32'(e.data));
                checkOutput("pulse_edge", edgeCount, e.edgeNum);
            end
        end
    end

    initial begin
        logic [31:0] v;
        bit          rs, sp, rq;
        logic [7:0]  sb;

        v = DEF;
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < ROUNDS; r++) v = refStep(v);
            refSeq[i] = v[31:24] ^ v[7:0];
        end
        mSeedWord = 32'd0;

        // Reset, then one request with default-seed keystream.
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        idle(2);
        request();
        idle(ROUNDS + 2);
        checkOutput("first_byte", 32'(hash_byte), 32'(refSeq[0]));

        // Seed 12 34 56 78 with gaps, then three requests.
        seedIn(8'h12);
        seedIn(8'h34);
        idle(3);
        seedIn(8'h56);
        seedIn(8'h78);
        for (int i = 0; i < 3; i++) begin
            request();
            idle(ROUNDS);
        end

        // All-zero seed falls back to the default seed.
        for (int i = 0; i < 4; i++) seedIn(8'h00);
        for (int i = 0; i < 3; i++) begin
            request();
            idle(ROUNDS + 1);
            checkOutput("zero_seed_byte", 32'(hash_byte), 32'(refSeq[i]));
        end

        // Requests while busy and while seeding, plus seed+request together.
        request();
        for (int i = 0; i < ROUNDS; i++) request();
        applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1);
        request();
        applyStimulus(1'b1, 1'b1, 8'h5E, 1'b1);
        request();
        seedIn(8'h01);
        applyStimulus(1'b1, 1'b1, 8'h9A, 1'b1);
        for (int i = 0; i < 2; i++) begin
            request();
            idle(ROUNDS);
        end

        // Reset during the second busy cycle aborts the byte.
        request();
        idle(1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        idle(2);
        checkOutput("abort_hash_byte", 32'(hash_byte), 32'd0);
        request();
        idle(ROUNDS + 1);
        checkOutput("abort_next_byte", 32'(hash_byte), 32'(refSeq[0]));

        // Five requests then a re-seed.
        for (int i = 0; i < 5; i++) begin
            request();
            idle(ROUNDS);
        end
        seedIn(8'hDE);
        seedIn(8'hAD);
        seedIn(8'hBE);
        seedIn(8'hEF);
        idle(2);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) != 0);
            sp = ($urandom_range(0, 99) < 8);
            sb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            rq = ($urandom_range(0, 99) < 35);
            applyStimulus(rs, sp, sb, rq);
        end

        idle(ROUNDS + 3);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
